// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the npc core.
// Holds the PC, issues one word fetch at a time over a req/rsp handshake,
// and presents each fetched instruction with its PC to the decoder.
// Execute redirects the PC at any time after BOOT. A response belonging to a
// fetch that was overtaken by a redirect is swallowed in DRAIN.
// Optional build macro: IFU_ALIGN_CHECK_EN adds a sticky fetch_misalign output
// that blocks requests to non word-aligned PCs until reset or an aligned redirect.

module ifu_fetch #(
    parameter int unsigned          XLEN     = 64,
    parameter logic [XLEN-1:0]      RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic            fetch_misalign
`endif
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            req_valid_q, inst_valid_q;
    logic            misalign_q, misalign_d;
    logic            req_fire;
    logic            redirect_take;

    // A request is only handed over while it is actually being presented.
    assign req_fire      = req_valid_q & imem_req_ready;
    // Redirects are meaningless before the first fetch, so BOOT ignores them.
    assign redirect_take = redirect_valid & (state_q != S_BOOT);

    // Next-state logic: redirect outranks every other event in each state.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (redirect_take) begin
                    pc_d    = redirect_pc;
                    // If the old address was taken this cycle its response is stale.
                    state_d = req_fire ? S_DRAIN : S_REQ;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_take) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    inst_d    = imem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_take) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_take) begin
                    pc_d = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

`ifdef IFU_ALIGN_CHECK_EN
    // Sticky misalignment flag: raised whenever REQ would present a misaligned
    // PC, dropped only by an aligned redirect (or reset).
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_take && (redirect_pc[1:0] == 2'b00)) begin
            misalign_d = 1'b0;
        end
        if ((state_d == S_REQ) && (pc_d[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign misalign_d = 1'b0;
`endif

    // State, PC and instruction registers plus registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            req_valid_q  <= (state_d == S_REQ) && !misalign_d;
            inst_valid_q <= (state_d == S_HOLD);
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the npc core.
- Holds the PC, issues word fetches to instruction memory over a request/response handshake, and presents each fetched instruction with its PC to the control decoder (opcode = inst[6:0], func3 = inst[14:12], func7 = inst[31:25]).
- Accepts redirect requests from execute for jal/jalr/taken branches.
- Discards stale in-flight fetches after a redirect.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 64'h80000000, first fetch address after reset.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address; equals current PC.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  fetch data valid; one response per accepted request, in order, never in the same cycle as its request.
- imem_rsp_data  input  32  fetched instruction word.
- inst_valid  output  1  instruction available to the decoder.
- inst  output  32  instruction word.
- inst_pc  output  XLEN  PC of inst.
- inst_ready  input  1  decoder/execute consumes inst this cycle.
- redirect_valid  input  1  control-flow redirect.
- redirect_pc  input  XLEN  redirect target.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=BOOT, pc=RESET_PC, inst=0, inst_pc=0, pending-drain cleared.
  - Outputs while in BOOT: imem_req_valid=0, inst_valid=0, imem_req_addr=pc.
  - Reset mid-fetch abandons the transaction; any response arriving after reset, before a new request is accepted, is ignored (state is never WAIT then).
- States and outputs:
  - BOOT: no outputs asserted; always -> REQ next cycle.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid, latch inst<=imem_rsp_data and inst_pc<=pc, then -> HOLD.
  - HOLD: inst_valid=1; inst and inst_pc stable. On inst_ready: pc<=pc+4, -> REQ.
  - DRAIN: a request is outstanding but stale. On imem_rsp_valid, discard data and -> REQ. inst_valid=0.
- Redirect: highest priority, sampled every cycle outside BOOT. pc<=redirect_pc, plus:
  - REQ with imem_req_ready=1 -> DRAIN.
  - REQ with imem_req_ready=0 -> REQ (new address presented next cycle).
  - WAIT with imem_rsp_valid=0 -> DRAIN.
  - WAIT with imem_rsp_valid=1 -> REQ; response discarded, never shown as inst.
  - HOLD -> REQ; the held instruction is dropped even if inst_ready=1 the same cycle.
  - DRAIN -> DRAIN; pc updated. If imem_rsp_valid=1 the same cycle -> REQ.
  - BOOT: redirect ignored.
- Redirect during rst: ignored; reset wins.
- Arithmetic: pc+4 is modulo 2^XLEN; 64'hFFFFFFFFFFFFFFFC+4 = 0. No alignment enforcement unless the optional feature is compiled in.
- Throughput/latency with zero-wait memory (req_ready=1, rsp one cycle after accept): REQ, WAIT, HOLD, so one instruction per 3 cycles. The first inst_valid rises 3 cycles after rst deasserts (BOOT, REQ, WAIT, then HOLD).
- Invariants:
  - At most one outstanding memory request.
  - imem_req_valid stays asserted with a stable address until accepted or redirected.

Optional Feature:
- Macro IFU_ALIGN_CHECK_EN.
- When defined, adds output fetch_misalign (1 bit, sticky, reset 0):
  - Set when the address to be requested has pc[1:0]!=0.
  - While it is set, the state holds in REQ with imem_req_valid forced to 0.
  - Cleared only by rst, or by a redirect to an aligned target, which then fetches normally.
- When undefined: no port; misaligned PCs are requested as-is.

Test Plan:
- Reset release, zero-wait memory returning 32'h00000013 for every address -> first inst_valid 3 cycles after rst falls, inst_pc=64'h80000000; next inst_pc=64'h80000004 three cycles later.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 with addr=64'h80000000 stable throughout; inst_valid stays 0.
- inst_ready held 0 for 4 cycles in HOLD -> inst and inst_pc stable, no new request issued; pc advances by exactly 4 after release.
- Redirect to 64'h80000100 in WAIT, response arrives 2 cycles later with 32'hDEADBEEF -> DEADBEEF never presented; next request addr=64'h80000100.
- Redirect in HOLD together with inst_ready=1, target 64'h80000200 -> next request addr=64'h80000200, not old pc+4.
- With IFU_ALIGN_CHECK_EN, redirect to 64'h80000102 -> fetch_misalign=1 and no request; then redirect to 64'h80000104 -> flag clears and a fetch is issued at 64'h80000104.
